// File: rtl/snn_debug_pkg.sv
// Shared types and sizing helpers for the SNN debug trace unit.
// SNN_TRACE_TIMESTAMP_EN widens each record by a 16-bit cycle stamp.
package snn_debug_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } trace_state_e;

  localparam int DROP_W = 8;
  localparam int TS_W   = 16;

  function automatic int rec_width(input int aw, input int dw);
`ifdef SNN_TRACE_TIMESTAMP_EN
    return TS_W + 1 + aw + 2 * dw;
`else
    return 1 + aw + 2 * dw;
`endif
  endfunction

  function automatic int frame_len(input int rw, input int lanes);
    return (rw + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/snn_trace_fifo.sv
// Synchronous FIFO with registered read data and registered status.
// Pointers wrap naturally because DEPTH is a power of two.
module snn_trace_fifo #(
  parameter int WIDTH = 74,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      if (push_ok && !pop_ok) level_d = level_q + 1'b1;
      if (!push_ok && pop_ok) level_d = level_q - 1'b1;
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/snn_debug_trace.sv
// Captures SNN bus cycles into a FIFO and streams them out over LANES pins.
// Define SNN_TRACE_TIMESTAMP_EN to prepend a 16-bit cycle stamp per record.
module snn_debug_trace
  import snn_debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 32,
  parameter int LANES      = 4
) (
  input  logic                    clk_snn,
  input  logic                    rst_i,
  input  logic                    debug_en_i,
  input  logic                    clr_i,
  input  logic                    wr_only_i,
  input  logic                    en_snn_i,
  input  logic                    we_snn_i,
  input  logic [ADDR_WIDTH-1:0]   addr_snn_i,
  input  logic [DATA_WIDTH-1:0]   data_in_snn_i,
  input  logic [DATA_WIDTH-1:0]   data_out_snn_i,
  output logic [LANES-1:0]        trace_sd_o,
  output logic                    trace_frame_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    overflow_o,
  output logic [DROP_W-1:0]       drop_cnt_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int REC_W = rec_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int F     = frame_len(REC_W, LANES);
  localparam int SH_W  = F * LANES;
  localparam int CW    = $clog2(F) + 1;

  logic [REC_W-1:0]  rec, rd_rec;
  logic              cap, push, pop, drop, full, empty;
  trace_state_e      state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

`ifdef SNN_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + 1'b1;
  assign rec  = {ts_q, we_snn_i, addr_snn_i, data_in_snn_i, data_out_snn_i};

  always_ff @(posedge clk_snn or posedge rst_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_d;
  end
`else
  assign rec = {we_snn_i, addr_snn_i, data_in_snn_i, data_out_snn_i};
`endif

  // A full FIFO still accepts when the drain pops in the same cycle.
  assign cap  = debug_en_i && en_snn_i && (!wr_only_i || we_snn_i);
  assign pop  = (state_q == IDLE) && !empty && !clr_i;
  assign push = cap && !clr_i && (!full || pop);
  assign drop = cap && !clr_i && full && !pop;

  snn_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_snn),
    .rst     (rst_i),
    .clr     (clr_i),
    .push    (push),
    .pop     (pop),
    .wr_data (rec),
    .rd_data (rd_rec),
    .full    (full),
    .empty   (empty),
    .level   (level_o)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (pop) state_d = LOAD;
      LOAD: begin
        sh_d    = SH_W'(rd_rec);
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d  = sh_q << LANES;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(F - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  always_comb begin
    ovf_d  = ovf_q | drop;
    drop_d = drop_q;
    if (drop && drop_q != '1) drop_d = drop_q + 1'b1;
    if (clr_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk_snn or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign trace_frame_o = (state_q == SHIFT);
  assign trace_sd_o    = trace_frame_o ? sh_q[SH_W-1 -: LANES] : '0;
  assign full_o        = full;
  assign empty_o       = empty;
  assign overflow_o    = ovf_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_snn_debug_trace.sv
// Directed bench for snn_debug_trace: 4-lane main DUT plus 1- and 8-lane
// instances sharing the same bus stimulus.
module tb_snn_debug_trace;

  localparam int DW = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, den, clr, wro, en, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;

  logic [3:0] sd4;
  logic [0:0] sd1;
  logic [7:0] sd8;
  logic       fr4, fr1, fr8;
  logic       full4, empty4, ovf4;
  logic       full1, empty1, ovf1;
  logic       full8, empty8, ovf8;
  logic [7:0] drop4, drop1, drop8;
  logic [5:0] lvl4, lvl1, lvl8;

  snn_debug_trace #(.LANES(4)) dut (
    .clk_snn(clk), .rst_i(rst), .debug_en_i(den), .clr_i(clr),
    .wr_only_i(wro), .en_snn_i(en), .we_snn_i(we), .addr_snn_i(addr),
    .data_in_snn_i(din), .data_out_snn_i(dout), .trace_sd_o(sd4),
    .trace_frame_o(fr4), .full_o(full4), .empty_o(empty4),
    .overflow_o(ovf4), .drop_cnt_o(drop4), .level_o(lvl4));

  snn_debug_trace #(.LANES(1)) dut_l1 (
    .clk_snn(clk), .rst_i(rst), .debug_en_i(den), .clr_i(clr),
    .wr_only_i(wro), .en_snn_i(en), .we_snn_i(we), .addr_snn_i(addr),
    .data_in_snn_i(din), .data_out_snn_i(dout), .trace_sd_o(sd1),
    .trace_frame_o(fr1), .full_o(full1), .empty_o(empty1),
    .overflow_o(ovf1), .drop_cnt_o(drop1), .level_o(lvl1));

  snn_debug_trace #(.LANES(8)) dut_l8 (
    .clk_snn(clk), .rst_i(rst), .debug_en_i(den), .clr_i(clr),
    .wr_only_i(wro), .en_snn_i(en), .we_snn_i(we), .addr_snn_i(addr),
    .data_in_snn_i(din), .data_out_snn_i(dout), .trace_sd_o(sd8),
    .trace_frame_o(fr8), .full_o(full8), .empty_o(empty8),
    .overflow_o(ovf8), .drop_cnt_o(drop8), .level_o(lvl8));

  int n_cmp = 0;
  int n_mis = 0;

  // Frame collectors: rebuild each frame from the lane stream.
  logic [79:0] q4[$];
  int          l4[$];
  logic [79:0] a4 = '0, a1 = '0, a8 = '0;
  int          c4 = 0, c1 = 0, c8 = 0;
  logic [79:0] last1 = '0, last8 = '0;
  int          len1 = 0, len8 = 0;

  always @(negedge clk) begin
    if (fr4) begin
      a4 = (a4 << 4) | 80'(sd4);
      c4++;
    end else if (c4 != 0) begin
      q4.push_back(a4);
      l4.push_back(c4);
      a4 = '0;
      c4 = 0;
    end
    if (fr1) begin
      a1 = (a1 << 1) | 80'(sd1);
      c1++;
    end else if (c1 != 0) begin
      last1 = a1;
      len1  = c1;
      a1    = '0;
      c1    = 0;
    end
    if (fr8) begin
      a8 = (a8 << 8) | 80'(sd8);
      c8++;
    end else if (c8 != 0) begin
      last8 = a8;
      len8  = c8;
      a8    = '0;
      c8    = 0;
    end
  end

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    en   = 1'b0;
    we   = 1'b0;
    addr = '0;
    din  = '0;
    dout = '0;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] di, input logic [DW-1:0] dd);
    en   = 1'b1;
    we   = w;
    addr = a;
    din  = di;
    dout = dd;
  endtask

  function automatic logic [79:0] mkrec(input logic w,
                                        input logic [AW-1:0] a,
                                        input logic [DW-1:0] di,
                                        input logic [DW-1:0] dd);
    return 80'({w, a, di, dd});
  endfunction

  task automatic wait_quiet(input string tag, input int maxc);
    int k  = 0;
    int st = 0;
    while (st < 3 && k < maxc) begin
      tick();
      k++;
      if (empty4 && !fr4) st++;
      else st = 0;
    end
    check(tag, 80'(st >= 3), 80'd1);
    tick(2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sd"}, 80'(sd4), 80'd0);
    check({tag, "_frame"}, 80'(fr4), 80'd0);
    check({tag, "_full"}, 80'(full4), 80'd0);
    check({tag, "_empty"}, 80'(empty4), 80'd1);
    check({tag, "_ovf"}, 80'(ovf4), 80'd0);
    check({tag, "_drop"}, 80'(drop4), 80'd0);
    check({tag, "_level"}, 80'(lvl4), 80'd0);
    check({tag, "_l1"}, 80'({sd1, fr1, full1, empty1, ovf1, drop1, lvl1}),
          80'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 6'd0}));
    check({tag, "_l8"}, 80'({sd8, fr8, full8, empty8, ovf8, drop8, lvl8}),
          80'({8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 6'd0}));
  endtask

  logic [79:0] exp_b[40];
  logic [79:0] r1;
  int          bad;

  initial begin
    rst = 1'b1;
    den = 1'b0;
    clr = 1'b0;
    wro = 1'b0;
    bus_idle();
    tick(3);
    check_reset("rst");
    rst = 1'b0;
    tick(2);

    // Single write: 3-cycle latency, 19/74/10-cycle frames
    den = 1'b1;
    r1  = mkrec(1'b1, 9'h1A5, 32'hDEADBEEF, 32'h12345678);
    drive(1'b1, 9'h1A5, 32'hDEADBEEF, 32'h12345678);
    tick();
    bus_idle();
    check("push_level", 80'(lvl4), 80'd1);
    check("lat_c1", 80'(fr4), 80'd0);
    tick();
    check("lat_c2", 80'(fr4), 80'd0);
    tick();
    check("lat_c3", 80'(fr4), 80'd1);
    check("first_nibble", 80'(sd4), 80'h3);
    tick(100);
    check("single_cnt", 80'(q4.size()), 80'd1);
    check("single_len4", 80'(l4[0]), 80'd19);
    check("single_dat4", q4[0], r1);
    check("single_len1", 80'(len1), 80'd74);
    check("single_dat1", last1, r1);
    check("single_len8", 80'(len8), 80'd10);
    check("single_dat8", last8, r1);

    // Write-only filter: 3 reads, 2 writes
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q4.delete();
    l4.delete();
    wro = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 9'(i + 16), 32'hC0DE0000 + 32'(i), 32'h0000BEEF ^ 32'(i));
      tick();
    end
    bus_idle();
    wait_quiet("wro_quiet", 200);
    check("wro_cnt", 80'(q4.size()), 80'd2);
    check("wro_f0", q4[0], mkrec(1'b1, 9'd17, 32'hC0DE0001, 32'h0000BEEE));
    check("wro_f1", q4[1], mkrec(1'b1, 9'd19, 32'hC0DE0003, 32'h0000BEEC));
    wro = 1'b0;

    // 40 back-to-back captures: 34 accepted, 6 dropped
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q4.delete();
    l4.delete();
    for (int i = 0; i < 40; i++) begin
      exp_b[i] = mkrec(i[0], 9'(i * 7), 32'hA0000000 + 32'(i),
                       ~(32'hA0000000 + 32'(i)));
      drive(i[0], 9'(i * 7), 32'hA0000000 + 32'(i), ~(32'hA0000000 + 32'(i)));
      tick();
    end
    bus_idle();
    check("burst_level", 80'(lvl4), 80'd32);
    check("burst_full", 80'(full4), 80'd1);
    check("burst_ovf", 80'(ovf4), 80'd1);
    check("burst_drop", 80'(drop4), 80'd6);
    wait_quiet("burst_quiet", 1000);
    check("burst_cnt", 80'(q4.size()), 80'd34);
    bad = 0;
    for (int i = 0; i < 34; i++) begin
      check($sformatf("burst_f%0d", i), q4[i], exp_b[i]);
      if (l4[i] != 19) bad++;
    end
    check("burst_lens", 80'(bad), 80'd0);
    check("drain_empty", 80'(empty4), 80'd1);
    check("ovf_sticky", 80'(ovf4), 80'd1);

    // Clear at frame cycle 5, with a capture in the same cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 9'(i), 32'h5555_0000 + 32'(i), 32'h0);
      tick();
    end
    bus_idle();
    bad = 0;
    while (!fr4 && bad < 20) begin
      tick();
      bad++;
    end
    tick(4);
    check("pre_clr_frame", 80'(fr4), 80'd1);
    clr = 1'b1;
    drive(1'b1, 9'h0FF, 32'h1, 32'h2);
    tick();
    clr = 1'b0;
    bus_idle();
    check("clr_frame", 80'(fr4), 80'd0);
    check("clr_sd", 80'(sd4), 80'd0);
    check("clr_empty", 80'(empty4), 80'd1);
    check("clr_level", 80'(lvl4), 80'd0);
    check("clr_drop", 80'(drop4), 80'd0);
    check("clr_ovf", 80'(ovf4), 80'd0);
    tick(2);
    q4.delete();
    l4.delete();
    tick(30);
    check("clr_noframe", 80'(q4.size()), 80'd0);

    // Reset mid-frame with 4 entries queued
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 9'(i + 100), 32'h7777_0000 + 32'(i), 32'h0);
      tick();
    end
    bus_idle();
    check("prerst_level", 80'(lvl4), 80'd4);
    check("prerst_frame", 80'(fr4), 80'd1);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    tick(2);
    rst = 1'b0;
    tick(2);
    q4.delete();
    l4.delete();
    tick(100);
    check("rst_noframe", 80'(q4.size()), 80'd0);
    check("rst_empty", 80'(empty4), 80'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/snn_debug_trace.md
SNN_DEBUG_TRACE -- requirements
Module: snn_debug_trace

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of SNN data in and data out.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, width of SNN address.
REQ-003 SHALL have parameter DEPTH, default 32, trace FIFO entries; power of two, at least 4.
REQ-004 SHALL have parameter LANES, default 4, serial output lanes; 1, 2, 4 or 8.
REQ-005 SHALL have port clk_snn, input, 1 bit, sole clock.
REQ-006 SHALL have port rst_i, input, 1 bit; reset is asynchronous and active-high.
REQ-007 SHALL have port debug_en_i, input, 1 bit, capture enable.
REQ-008 SHALL have port clr_i, input, 1 bit, synchronous flush.
REQ-009 SHALL have port wr_only_i, input, 1 bit, filter that captures writes only.
REQ-010 SHALL have ports en_snn_i (1), we_snn_i (1), addr_snn_i (ADDR_WIDTH), data_in_snn_i (DATA_WIDTH) and data_out_snn_i (DATA_WIDTH), all inputs carrying the SNN core bus.
REQ-011 SHALL have port trace_sd_o, output, LANES bits, serial trace data.
REQ-012 SHALL have port trace_frame_o, output, 1 bit, high on every cycle that carries valid trace bits.
REQ-013 SHALL have ports full_o and empty_o (1 bit each), overflow_o (1 bit, sticky), drop_cnt_o (8 bits) and level_o ($clog2(DEPTH)+1 bits), all outputs.

Function
REQ-014 SHALL capture a record on every cycle where debug_en_i && en_snn_i && (!wr_only_i || we_snn_i).
- Record = {we, addr, data_in, data_out}, MSB-first.
- REC_W = 1 + ADDR_WIDTH + 2*DATA_WIDTH.
REQ-015 SHALL accept a capture when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Otherwise the record is dropped, overflow_o is set, and drop_cnt_o increments, saturating at 255.
REQ-016 SHALL implement an FSM with states IDLE, LOAD and SHIFT.
- IDLE -> LOAD: when the FIFO is not empty; the pop happens in this cycle.
- LOAD: registers the FIFO output into a shift register, which is zero-padded at the MSB to F*LANES bits, where F = ceil(REC_W/LANES).
- SHIFT: drives the top LANES bits on trace_sd_o and shifts left by LANES each cycle, for exactly F cycles, with trace_frame_o high.
- SHIFT -> IDLE: after cycle F, so there is at least one idle cycle between frames.
REQ-017 SHALL drive trace_sd_o to 0 whenever trace_frame_o is low.
REQ-018 SHALL continue draining independently of debug_en_i; deasserting debug_en_i stops captures only, and the current frame completes.
REQ-019 SHALL give level_o, full_o and empty_o registered values consistent with each other.
- level_o equals the FIFO occupancy.
- Simultaneous push and pop leaves level_o unchanged.
- Pointers wrap modulo DEPTH.
REQ-020 SHALL, on clr_i, in the next cycle:
- empty the FIFO;
- abort any frame (trace_frame_o goes low, FSM returns to IDLE);
- clear overflow_o and drop_cnt_o.
A capture in the same cycle as clr_i is discarded. clr_i has priority over all other events.
REQ-021 SHALL have a capture-to-first-frame-bit latency of 3 cycles from an empty, IDLE state: push, pop, load, then the first SHIFT cycle.

Reset
REQ-022 SHALL, while rst_i is high, force the following values:
- trace_sd_o = 0, trace_frame_o = 0;
- full_o = 0, empty_o = 1;
- overflow_o = 0, drop_cnt_o = 0, level_o = 0;
- FSM in IDLE, with FIFO pointers and the timestamp counter at 0.
REQ-023 SHALL discard a partially sent frame when rst_i asserts mid-frame; output resumes only with new captures after release.

Configuration
REQ-024 SHALL, with SNN_TRACE_TIMESTAMP_EN defined, keep a 16-bit free-running wrapping cycle counter.
- Its value is prepended at the MSB of each record, so REC_W grows by 16.
REQ-025 SHALL, without SNN_TRACE_TIMESTAMP_EN, contain no counter and produce records exactly as defined in REQ-014.

Structure
REQ-026 SHALL take the FSM state enum, the REC_W/F computation functions and the drop-counter width constant from the shared package snn_debug_pkg.
REQ-027 SHALL instantiate one sub-module, snn_trace_fifo: a synchronous FIFO with registered read data, parametrised width and depth, and push/pop/full/empty/level ports.

Verification
REQ-028 SHALL cover the following directed scenarios. Defaults apply with no timestamp: REC_W=74, F=19.
- Single write we=1, addr=0x1A5, data_in=0xDEADBEEF, data_out=0x12345678 -> after 3 cycles, trace_frame_o is high for 19 cycles; the lane stream reconstructs 00 | 1 | 1A5 | DEADBEEF | 12345678.
- 40 back-to-back captures with no drain possible (frames slower than pushes) -> full_o=1 at level 32, overflow_o=1, drop_cnt_o equals the records dropped (including pops during the burst), and no frame content is corrupted.
- wr_only_i=1 with 3 reads and 2 writes -> exactly 2 frames.
- clr_i asserted at cycle 5 of a frame -> trace_frame_o=0 next cycle, empty_o=1, drop_cnt_o=0.
- rst_i pulsed mid-frame with 4 entries queued -> all outputs at reset values and no further frames.
- LANES=1, and separately LANES=8 -> frame lengths of 74 and 10 cycles respectively, with data intact.
